io_uart: RTL and testbench
==========================

# io_uart

Serial peripheral at the far end of the CPU's `io` port. It accepts 16-bit output words written over the shared bus, queues them, and transmits them as two 8-bit UART frames. It also receives UART frames, pairs them into 16-bit input words, and drives those words onto the bus when the CPU enables input. It sits beside `io` in `datapath` and replaces the bare output/input latches with a real serial link.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; even, ≥ 4.
- `FIFO_DEPTH`, 4, TX FIFO depth in words; power of two, ≥ 2.

- `i_clk`  in  1  system clock, rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_data`  in  16  bus word to transmit.
- `i_wrOut`  in  1  write strobe, sampled on the rising edge.
- `i_inNOe`  in  1  active-low bus enable for `o_data`.
- `o_data`  out  16  RX holding register when `i_inNOe`=0; `'z` otherwise.
- `o_tx`  out  1  serial output, idles high.
- `i_rx`  in  1  serial input, asynchronous.
- `o_txFull`  out  1  TX FIFO holds `FIFO_DEPTH` words.
- `o_txOverflow`  out  1  sticky: a write was dropped.
- `o_rxValid`  out  1  holding register contains an unread word.
- `o_rxOverrun`  out  1  sticky: an unread word was overwritten.
- `o_rxFrameErr`  out  1  sticky: a bad frame was received.

## Operation
- **Reset values:** `o_tx`=1; every flag is 0; TX FIFO is empty; holding register is 0x0000; both FSMs are IDLE; RX byte phase is LOW. Sticky flags clear only on reset.
- **TX FIFO:** `i_wrOut`=1 with FIFO not full pushes `i_data`. With FIFO full, the write is dropped and `o_txOverflow` is set.
- **TX FSM states:** IDLE → START → DATA(8) → [PARITY] → STOP, repeated for two bytes per word.
  - IDLE with FIFO not empty pops one word and enters START.
  - Low byte is sent first, then high byte; bits go LSB first.
  - Start bit is 0, stop bit is 1.
  - After the high byte's STOP: pop the next word if available, otherwise go to IDLE.
- **RX input:** `i_rx` passes through a 2-FF synchronizer.
- **RX FSM states:** IDLE → START → DATA → [PARITY] → STOP.
  - IDLE detects a falling edge on the synchronized input.
  - START re-samples at `CLKS_PER_BIT/2`; if the line is high, it is a false start and the FSM returns to IDLE.
  - Data, parity and stop bits are sampled at mid-bit.
- **RX stop bit:**
  - Stop bit = 0: set `o_rxFrameErr`, discard the byte, reset the byte phase to LOW.
  - Good byte in phase LOW: store it as the low byte; phase becomes HIGH.
  - Good byte in phase HIGH: load {high, low} into the holding register, set `o_rxValid`, phase becomes LOW. If `o_rxValid` was already 1, also set `o_rxOverrun`.
- **Bus read:** a rising edge with `i_inNOe`=0 clears `o_rxValid`. If a word completes on the same edge, the load wins and `o_rxValid` stays 1.
- `o_data` is purely combinational from `i_inNOe` and the holding register.

## Timing
- Push at edge N → `o_tx` falls at edge N+1 (FSM was IDLE).
- One word takes 2 × 10 × `CLKS_PER_BIT` cycles, or 2 × 11 × `CLKS_PER_BIT` with parity. Back-to-back words have no idle gap.
- `o_txFull` updates on the edge after the push or pop. Simultaneous push and pop on a full FIFO is accepted.
- `o_rxValid` rises one cycle after the high byte's stop-bit sample.
- Reset mid-frame: `o_tx` goes to 1 immediately; a partial RX word is discarded.

## Configuration
- `IO_UART_PARITY_EN` defined: an even-parity bit follows the data bits on both TX and RX. An RX parity mismatch sets `o_rxFrameErr`, discards the byte and resets the byte phase to LOW.
- Not defined: 8N1 framing; no PARITY state exists.

## Test plan
- Reset low mid-transmission, `CLKS_PER_BIT`=16 → `o_tx`=1 within the same cycle, `o_txFull`=0, all flags 0, no further activity until a new write.
- Write 0xA55A → `o_tx` carries 0x5A then 0xA5, LSB first, each with start/stop bits; 320 cycles total; line high afterwards.
- Six back-to-back writes, depth 4 → first word popped, next four queued, sixth dropped; `o_txFull`=1, `o_txOverflow`=1; the five accepted words transmit in order.
- Loopback `o_tx`→`i_rx`, send 0x1234 → `o_rxValid`=1 after the frame. `i_inNOe`=0 gives `o_data`=0x1234 and clears valid; `i_inNOe`=1 gives `'z`.
- RX byte with stop bit 0, then good bytes 0x34, 0x12 → `o_rxFrameErr`=1, then holding register 0x1234. A second word arriving before the read sets `o_rxOverrun`.
- 4-cycle low glitch on `i_rx` → no byte, no flags; with `IO_UART_PARITY_EN`, a wrong parity bit → `o_rxFrameErr`=1.

Source files
------------

// File: rtl/io_uart.sv
// io_uart: word-oriented UART at the CPU io port; TX word FIFO, 16-bit RX holding register.
// Define IO_UART_PARITY_EN for even parity on TX and RX (8E1); default build is 8N1.
module io_uart #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_data,
  input  logic        i_wrOut,
  input  logic        i_inNOe,
  output logic [15:0] o_data,
  output logic        o_tx,
  input  logic        i_rx,
  output logic        o_txFull,
  output logic        o_txOverflow,
  output logic        o_rxValid,
  output logic        o_rxOverrun,
  output logic        o_rxFrameErr
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

`ifdef IO_UART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rxState_t;
`else
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
`endif

  // ---------------- TX FIFO ----------------
  logic [15:0]      fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [OCC_W-1:0] fifoOcc, fifoOccNext;
  logic             txPush, txPop, txWordEnd;

  txState_t         txState;
  logic [CNT_W-1:0] txCnt;
  logic [2:0]       txBit;
  logic [7:0]       txByte, txHighByte;
  logic             txHigh;

  // A full FIFO still accepts a write when the TX side pops on the same edge
  assign txWordEnd   = (txState == TX_STOP) && txHigh && (txCnt == BIT_LAST);
  assign txPop       = (fifoOcc != '0) && ((txState == TX_IDLE) || txWordEnd);
  assign txPush      = i_wrOut && ((fifoOcc != OCC_FULL) || txPop);
  assign fifoOccNext = fifoOcc + OCC_W'(txPush) - OCC_W'(txPop);

  always_ff @(posedge i_clk) begin
    if (txPush) fifoMem[wrPtr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      fifoOcc      <= '0;
      o_txFull     <= 1'b0;
      o_txOverflow <= 1'b0;
    end else begin
      if (txPush) wrPtr <= wrPtr + PTR_W'(1);
      if (txPop)  rdPtr <= rdPtr + PTR_W'(1);
      fifoOcc  <= fifoOccNext;
      o_txFull <= (fifoOccNext == OCC_FULL);
      if (i_wrOut && !txPush) o_txOverflow <= 1'b1;
    end
  end

  // ---------------- TX FSM: low byte then high byte, LSB first ----------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      txState    <= TX_IDLE;
      txCnt      <= '0;
      txBit      <= '0;
      txByte     <= '0;
      txHighByte <= '0;
      txHigh     <= 1'b0;
      o_tx       <= 1'b1;
    end else if (txPop) begin
      txByte     <= fifoMem[rdPtr][7:0];
      txHighByte <= fifoMem[rdPtr][15:8];
      txHigh     <= 1'b0;
      txCnt      <= '0;
      o_tx       <= 1'b0;
      txState    <= TX_START;
    end else begin
      case (txState)
        TX_IDLE: o_tx <= 1'b1;
        TX_START:
          if (txCnt == BIT_LAST) begin
            txCnt   <= '0;
            txBit   <= '0;
            o_tx    <= txByte[0];
            txState <= TX_DATA;
          end else txCnt <= txCnt + CNT_W'(1);
        TX_DATA:
          if (txCnt == BIT_LAST) begin
            txCnt <= '0;
            if (txBit == 3'd7) begin
`ifdef IO_UART_PARITY_EN
              o_tx    <= ^txByte;
              txState <= TX_PARITY;
`else
              o_tx    <= 1'b1;
              txState <= TX_STOP;
`endif
            end else begin
              txBit <= txBit + 3'd1;
              o_tx  <= txByte[txBit + 3'd1];
            end
          end else txCnt <= txCnt + CNT_W'(1);
`ifdef IO_UART_PARITY_EN
        TX_PARITY:
          if (txCnt == BIT_LAST) begin
            txCnt   <= '0;
            o_tx    <= 1'b1;
            txState <= TX_STOP;
          end else txCnt <= txCnt + CNT_W'(1);
`endif
        TX_STOP:
          if (txCnt == BIT_LAST) begin
            txCnt <= '0;
            if (!txHigh) begin
              txHigh  <= 1'b1;
              txByte  <= txHighByte;
              o_tx    <= 1'b0;
              txState <= TX_START;
            end else txState <= TX_IDLE;
          end else txCnt <= txCnt + CNT_W'(1);
        default: begin
          o_tx    <= 1'b1;
          txState <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX: synchronizer, byte FSM, word pairing ----------------
  rxState_t         rxState;
  logic             rxMeta, rxSync, rxSyncD;
  logic [CNT_W-1:0] rxCnt;
  logic [2:0]       rxBit;
  logic [7:0]       rxShift, rxLow;
  logic             rxPhaseHigh, rxBad;
  logic [15:0]      rxHold;

`ifdef IO_UART_PARITY_EN
  logic rxParErr;
  assign rxBad = !rxSync || rxParErr;
`else
  assign rxBad = !rxSync;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rxMeta       <= 1'b1;
      rxSync       <= 1'b1;
      rxSyncD      <= 1'b1;
      rxState      <= RX_IDLE;
      rxCnt        <= '0;
      rxBit        <= '0;
      rxShift      <= '0;
      rxLow        <= '0;
      rxPhaseHigh  <= 1'b0;
      rxHold       <= '0;
      o_rxValid    <= 1'b0;
      o_rxOverrun  <= 1'b0;
      o_rxFrameErr <= 1'b0;
`ifdef IO_UART_PARITY_EN
      rxParErr     <= 1'b0;
`endif
    end else begin
      rxMeta  <= i_rx;
      rxSync  <= rxMeta;
      rxSyncD <= rxSync;
      // A bus read clears valid; a word completing on this edge overrides it below
      if (!i_inNOe) o_rxValid <= 1'b0;
      case (rxState)
        RX_IDLE:
          if (rxSyncD && !rxSync) begin
            rxCnt   <= '0;
            rxState <= RX_START;
          end
        RX_START:
          if (rxCnt == HALF_LAST) begin
            rxCnt   <= '0;
            rxBit   <= '0;
            rxState <= rxSync ? RX_IDLE : RX_DATA;
          end else rxCnt <= rxCnt + CNT_W'(1);
        RX_DATA:
          if (rxCnt == BIT_LAST) begin
            rxCnt   <= '0;
            rxShift <= {rxSync, rxShift[7:1]};
            rxBit   <= rxBit + 3'd1;
`ifdef IO_UART_PARITY_EN
            if (rxBit == 3'd7) rxState <= RX_PARITY;
`else
            if (rxBit == 3'd7) rxState <= RX_STOP;
`endif
          end else rxCnt <= rxCnt + CNT_W'(1);
`ifdef IO_UART_PARITY_EN
        RX_PARITY:
          if (rxCnt == BIT_LAST) begin
            rxCnt    <= '0;
            rxParErr <= (^rxShift) ^ rxSync;
            rxState  <= RX_STOP;
          end else rxCnt <= rxCnt + CNT_W'(1);
`endif
        RX_STOP:
          if (rxCnt == BIT_LAST) begin
            rxCnt   <= '0;
            rxState <= RX_IDLE;
            if (rxBad) begin
              o_rxFrameErr <= 1'b1;
              rxPhaseHigh  <= 1'b0;
            end else if (!rxPhaseHigh) begin
              rxLow       <= rxShift;
              rxPhaseHigh <= 1'b1;
            end else begin
              rxHold      <= {rxShift, rxLow};
              o_rxValid   <= 1'b1;
              rxPhaseHigh <= 1'b0;
              if (o_rxValid) o_rxOverrun <= 1'b1;
            end
          end else rxCnt <= rxCnt + CNT_W'(1);
        default: rxState <= RX_IDLE;
      endcase
    end
  end

  assign o_data = i_inNOe ? 16'hzzzz : rxHold;

endmodule

// File: tb/tb_io_uart.sv
// Scoreboard bench for io_uart: serial TX monitor and RX reader pop expected words from queues.
module tb_io_uart;
  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;
`ifdef IO_UART_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam int unsigned WORD_CYCLES = 2 * FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        resetN;
  logic [15:0] wrData;
  logic        wrOut;
  logic        cpuRd, monRd;
  logic        inNOe;
  logic [15:0] rdData;
  logic        txLine, rxIn, rxDrv, loopback;
  logic        txFull, txOverflow, rxValid, rxOverrun, rxFrameErr;
`ifdef IO_UART_PARITY_EN
  logic        parFlip = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] txQ[$];
  logic [15:0] rxQ[$];
  bit txMonEn = 1'b0;
  bit rxMonEn = 1'b0;

  assign inNOe = !(cpuRd || monRd);
  assign rxIn  = loopback ? txLine : rxDrv;

  always #5 clk = ~clk;

  io_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(resetN), .i_data(wrData), .i_wrOut(wrOut), .i_inNOe(inNOe),
    .o_data(rdData), .o_tx(txLine), .i_rx(rxIn), .o_txFull(txFull),
    .o_txOverflow(txOverflow), .o_rxValid(rxValid), .o_rxOverrun(rxOverrun),
    .o_rxFrameErr(rxFrameErr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Expected frame derived from the word: bytes low-then-high, each LSB first, even parity
  initial begin : txMon
    logic [7:0]  b, lowB;
    logic [15:0] exp;
    bit          haveLow;
    haveLow = 1'b0;
    forever begin
      @(negedge txLine);
      if (txMonEn) begin
        repeat (CPB / 2 + 1) @(negedge clk);
        chk("tx_start_bit", 32'(txLine), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txLine;
        end
`ifdef IO_UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        chk("tx_parity_bit", 32'(txLine), 32'($countones(b) % 2));
`endif
        repeat (CPB) @(negedge clk);
        chk("tx_stop_bit", 32'(txLine), 32'd1);
        if (!haveLow) begin
          lowB    = b;
          haveLow = 1'b1;
        end else begin
          haveLow = 1'b0;
          if (txQ.size() == 0) fail("tx_word", $sformatf("unexpected word %h", {b, lowB}));
          else begin
            exp = txQ.pop_front();
            chk("tx_word", 32'({b, lowB}), 32'(exp));
          end
        end
      end
    end
  end

  // Bus reader: reads each completed word, then checks valid clears and bus releases
  initial begin : rxMon
    logic [15:0] exp;
    monRd = 1'b0;
    forever begin
      @(negedge clk);
      if (rxMonEn && rxValid) begin
        monRd = 1'b1;
        #1;
        if (rxQ.size() == 0) fail("rx_word", $sformatf("unexpected word %h", rdData));
        else begin
          exp = rxQ.pop_front();
          chk("rx_word", 32'(rdData), 32'(exp));
        end
        @(negedge clk);
        monRd = 1'b0;
        #1;
        chk("rx_valid_cleared", 32'(rxValid), 32'd0);
        chk("rx_bus_released", 32'(rdData === 16'hzzzz), 32'd1);
      end
    end
  end

  task automatic waitQueues(input string name, input int limit);
    int n = 0;
    while ((txQ.size() != 0 || rxQ.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(txQ.size() + rxQ.size()), 32'd0);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rxDrv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxDrv = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef IO_UART_PARITY_EN
    rxDrv = (^b) ^ parFlip;
    repeat (CPB) @(negedge clk);
`endif
    rxDrv = stopBit;
    repeat (CPB) @(negedge clk);
    rxDrv = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic cpuRead(input string name, input logic [15:0] exp);
    cpuRd = 1'b1;
    #1;
    chk(name, 32'(rdData), 32'(exp));
    @(negedge clk);
    cpuRd = 1'b0;
    #1;
    chk({name, "_valid_cleared"}, 32'(rxValid), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] w, w2;
    logic [15:0] burst [6];
    int lows, n;
    resetN = 1'b0; wrOut = 1'b0; wrData = '0; cpuRd = 1'b0; rxDrv = 1'b1; loopback = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(txLine), 32'd1);
    chk("reset_full", 32'(txFull), 32'd0);
    chk("reset_overflow", 32'(txOverflow), 32'd0);
    chk("reset_valid", 32'(rxValid), 32'd0);
    chk("reset_overrun", 32'(rxOverrun), 32'd0);
    chk("reset_frame_err", 32'(rxFrameErr), 32'd0);
    cpuRd = 1'b1; #1;
    chk("reset_hold", 32'(rdData), 32'h0);
    cpuRd = 1'b0; #1;
    chk("bus_z", 32'(rdData === 16'hzzzz), 32'd1);
    resetN = 1'b1;
    @(negedge clk);

    // Fill and overflow, then reset in the middle of a frame
    for (int i = 0; i < 6; i++) begin
      wrData = 16'h0000; wrOut = 1'b1;
      @(negedge clk);
    end
    wrOut = 1'b0;
    repeat (40) @(negedge clk);
    chk("pre_reset_tx_low", 32'(txLine), 32'd0);
    chk("pre_reset_full", 32'(txFull), 32'd1);
    chk("pre_reset_overflow", 32'(txOverflow), 32'd1);
    resetN = 1'b0; #1;
    chk("midframe_reset_tx", 32'(txLine), 32'd1);
    chk("midframe_reset_full", 32'(txFull), 32'd0);
    chk("midframe_reset_overflow", 32'(txOverflow), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    lows = 0;
    repeat (400) begin
      @(negedge clk);
      if (!txLine) lows++;
    end
    chk("quiet_after_reset", 32'(lows), 32'd0);

    // 0xA55A then a zero word: start latency and exact word length without gap
    txMonEn = 1'b1;
    txQ.push_back(16'hA55A);
    txQ.push_back(16'h0000);
    wrData = 16'hA55A; wrOut = 1'b1;
    @(negedge clk);
    wrData = 16'h0000;
    chk("tx_idle_after_push_edge", 32'(txLine), 32'd1);
    @(negedge clk);
    wrOut = 1'b0;
    chk("tx_start_next_edge", 32'(txLine), 32'd0);
    repeat (WORD_CYCLES - 1) @(negedge clk);
    chk("word_last_cycle_stop", 32'(txLine), 32'd1);
    @(negedge clk);
    chk("next_word_no_gap", 32'(txLine), 32'd0);
    waitQueues("drain_a55a", 3 * WORD_CYCLES);
    chk("line_idle_high", 32'(txLine), 32'd1);

    // Six back-to-back writes: five accepted in order, sixth dropped
    for (int i = 0; i < 6; i++) begin
      burst[i] = 16'($urandom);
      if (i < 5) txQ.push_back(burst[i]);
    end
    for (int i = 0; i < 6; i++) begin
      wrData = burst[i]; wrOut = 1'b1;
      @(negedge clk);
    end
    wrOut = 1'b0;
    chk("burst_full", 32'(txFull), 32'd1);
    chk("burst_overflow", 32'(txOverflow), 32'd1);
    waitQueues("drain_burst", 7 * WORD_CYCLES);
    chk("burst_not_full", 32'(txFull), 32'd0);

    // Loopback of random words with random spacing
    loopback = 1'b1;
    rxMonEn  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = (i == 0) ? 16'h1234 : 16'($urandom);
      n = 0;
      while (txFull && n < 4 * WORD_CYCLES) begin
        @(negedge clk);
        n++;
      end
      if (txFull) fail("loop_full_wait", "FIFO stayed full");
      txQ.push_back(w);
      rxQ.push_back(w);
      wrData = w; wrOut = 1'b1;
      @(negedge clk);
      wrOut = 1'b0;
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end
    waitQueues("drain_loopback", 12 * WORD_CYCLES);
    chk("loop_overrun", 32'(rxOverrun), 32'd0);
    chk("loop_frame_err", 32'(rxFrameErr), 32'd0);
    rxMonEn  = 1'b0;
    loopback = 1'b0;

    // Bad stop bit in the high phase resets pairing, then a good word
    w = 16'($urandom);
    sendByte(8'h77, 1'b1);
    sendByte(8'($urandom), 1'b0);
    chk("stop0_frame_err", 32'(rxFrameErr), 32'd1);
    chk("stop0_no_valid", 32'(rxValid), 32'd0);
    sendByte(w[7:0], 1'b1);
    sendByte(w[15:8], 1'b1);
    chk("pair_valid", 32'(rxValid), 32'd1);
    cpuRead("pair_word", w);

    // Two unread words: the second sets overrun and replaces the first
    w  = 16'($urandom);
    w2 = 16'($urandom);
    sendByte(w[7:0], 1'b1);
    sendByte(w[15:8], 1'b1);
    chk("first_unread_valid", 32'(rxValid), 32'd1);
    chk("first_unread_no_overrun", 32'(rxOverrun), 32'd0);
    sendByte(w2[7:0], 1'b1);
    sendByte(w2[15:8], 1'b1);
    chk("overrun_set", 32'(rxOverrun), 32'd1);
    cpuRead("overrun_word", w2);

    // Short glitch is a false start and leaves byte pairing untouched
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    repeat (4) @(negedge clk);
    rxDrv = 1'b0;
    repeat (4) @(negedge clk);
    rxDrv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_no_valid", 32'(rxValid), 32'd0);
    chk("glitch_no_frame_err", 32'(rxFrameErr), 32'd0);
    chk("glitch_no_overrun", 32'(rxOverrun), 32'd0);
    w = 16'($urandom);
    sendByte(w[7:0], 1'b1);
    sendByte(w[15:8], 1'b1);
    cpuRead("after_glitch_word", w);

`ifdef IO_UART_PARITY_EN
    parFlip = 1'b1;
    sendByte(8'($urandom), 1'b1);
    parFlip = 1'b0;
    chk("parity_frame_err", 32'(rxFrameErr), 32'd1);
    chk("parity_no_valid", 32'(rxValid), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
